// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and 8N1 frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Line level of the start and stop bits of an 8N1 frame
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_sync2 (
  input  logic bclk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture of the asynchronous input into the bclk domain
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: oversampled start validation, mid-bit sampling into a
// shift register, and a host-facing receive buffer with ready/frame/overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic                      rd,
  output logic [UART_DATA_BITS-1:0] d_out,
  output logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun_err
);

  localparam int DATA_W = UART_DATA_BITS;
  localparam int CNT_W  = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_W - 1);

  logic              w_rx_s;
  logic              w_xfer;

  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_rsr;
  logic [DATA_W-1:0] r_rbr;
  logic              r_ready;
  logic              r_ferr;
  logic              r_ovr;

  uart_sync2 u_sync (
    .bclk  (bclk),
    .reset (reset),
    .i_d   (rx_in),
    .o_q   (w_rx_s)
  );

  // The stop-bit sample point is the moment the shift register is handed to the host
  assign w_xfer = (r_state == STOP) && (r_sample_cnt == FULL_LAST);

  // Frame FSM: start validation at half a bit, then one sample per bit period at mid-bit
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_rsr        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_sample_cnt <= '0;
          if (w_rx_s == START_BIT) r_state <= START;
        end
        START: begin
          if (r_sample_cnt == HALF_LAST) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            // A line that is high again at mid start bit was a glitch
            r_state      <= (w_rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            r_sample_cnt <= r_sample_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (r_sample_cnt == FULL_LAST) begin
            r_sample_cnt <= '0;
            r_rsr        <= {w_rx_s, r_rsr[DATA_W-1:1]};
            if (r_bit_cnt == LAST_BIT) r_state <= STOP;
            else                       r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_sample_cnt <= r_sample_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (r_sample_cnt == FULL_LAST) begin
            r_sample_cnt <= '0;
            // A low stop bit may be a break; wait for the line to return high
            r_state      <= (w_rx_s == STOP_BIT) ? IDLE : WAIT_IDLE;
          end else begin
            r_sample_cnt <= r_sample_cnt + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s == STOP_BIT) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Receive buffer and status flags; a new byte takes priority over a host read
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_rbr   <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_xfer) begin
      r_rbr   <= r_rsr;
      r_ready <= 1'b1;
      r_ferr  <= (w_rx_s != STOP_BIT);
      // An unread byte is lost unless the host reads it in this same cycle
      if (r_ready) r_ovr <= ~rd;
    end else if (rd && r_ready) begin
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign d_out       = r_rbr;
  assign rx_ready    = r_ready;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame scenarios plus randomized
// traffic, checked every cycle against a sample-point model of the 8N1 receiver.
module tb_uart_receiver;

  localparam int OS = 8;

  logic       bclk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] d_out;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;
  bit  rnd_rd = 1'b0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .bclk        (bclk),
    .reset       (reset),
    .rx_in       (rx_in),
    .rd          (rd),
    .d_out       (d_out),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 bclk = ~bclk;

  // ---------------- reference model ----------------
  // The line is seen two clocks late. A frame is timed from the first low
  // sample seen while hunting: start check 4 clocks later, data bit i at
  // 4+8*(i+1), stop at 76, and the byte appears right after the stop sample.
  bit         m_hunt, m_wait, m_frame;
  int         m_f0, m_p;
  bit         m_s1, m_s2;
  logic [7:0] m_data;
  logic [7:0] e_d;
  bit         e_rdy, e_fe, e_ov;

  task automatic model_clear();
    m_hunt = 1'b1; m_wait = 1'b0; m_frame = 1'b0;
    m_f0 = 0; m_p = 0; m_s1 = 1'b1; m_s2 = 1'b1; m_data = '0;
    e_d = '0; e_rdy = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
  endtask

  initial begin
    bit rs, xfer, stop_v;
    int off;
    model_clear();
    forever begin
      @(posedge bclk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        rs = m_s2; m_s2 = m_s1; m_s1 = rx_in;
        xfer = 1'b0; stop_v = 1'b1;
        if (m_hunt) begin
          if (!rs) begin m_hunt = 1'b0; m_frame = 1'b1; m_f0 = m_p; end
        end else if (m_wait) begin
          if (rs) begin m_wait = 1'b0; m_hunt = 1'b1; end
        end else if (m_frame) begin
          off = m_p - m_f0;
          if (off == OS / 2) begin
            if (rs) begin m_frame = 1'b0; m_hunt = 1'b1; end
          end else if (off > OS / 2 && off <= OS / 2 + 8 * OS && ((off - OS / 2) % OS) == 0) begin
            m_data[(off - OS / 2) / OS - 1] = rs;
          end else if (off == OS / 2 + 9 * OS) begin
            xfer = 1'b1; stop_v = rs; m_frame = 1'b0;
            if (rs) m_hunt = 1'b1; else m_wait = 1'b1;
          end
        end
        if (xfer) begin
          if (e_rdy) e_ov = !rd;
          e_d = m_data; e_rdy = 1'b1; e_fe = !stop_v;
        end else if (rd && e_rdy) begin
          e_rdy = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
        end
        m_p++;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge bclk);
      #1;
      if (chk_en) begin
        n_cmp++;
        if ({d_out, rx_ready, frame_err, overrun_err} !== {e_d, e_rdy, e_fe, e_ov}) begin
          n_fail++;
          $display("FAIL cycle_cmp t=%0t: got d=%02h rdy=%b fe=%b ov=%b, expected d=%02h rdy=%b fe=%b ov=%b",
                   $time, d_out, rx_ready, frame_err, overrun_err, e_d, e_rdy, e_fe, e_ov);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit rand_rd();
    return rnd_rd && ($urandom_range(0, 15) == 0);
  endfunction

  task automatic drive_level(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge bclk);
      rx_in = lvl;
      rd = rand_rd();
    end
  endtask

  // Drives one 10-bit frame; rd_at selects a clock index within the frame for a rd pulse
  task automatic send_frame(input logic [7:0] data, input bit stop, input int rd_at);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int k = 0; k < 10 * OS; k++) begin
      @(negedge bclk);
      rx_in = fr[k / OS];
      rd = (k == rd_at) || rand_rd();
    end
  endtask

  task automatic pulse_rd();
    @(negedge bclk);
    rx_in = 1'b1; rd = 1'b1;
    @(negedge bclk);
    rd = 1'b0;
    #1;
  endtask

  task automatic settle(input int n);
    drive_level(1'b1, n);
    @(negedge bclk);
    rd = 1'b0;
    #1;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    bit st;
    int kind;
    rx_in = 1'b1; rd = 1'b0; reset = 1'b1;
    repeat (3) @(negedge bclk);
    #1;
    check("reset_d_out", d_out, 8'h00);
    check("reset_rx_ready", rx_ready, 1'b0);
    check("reset_flags", {frame_err, overrun_err}, 2'b00);
    chk_en = 1'b1;
    @(negedge bclk);
    reset = 1'b0;
    settle(10);

    // Single clean frame, then host read
    send_frame(8'hA5, 1'b1, -1);
    settle(6);
    check("t1_d_out", d_out, 8'hA5);
    check("t1_ready", rx_ready, 1'b1);
    check("t1_flags", {frame_err, overrun_err}, 2'b00);
    pulse_rd();
    check("t1_ready_after_rd", rx_ready, 1'b0);
    check("t1_d_hold", d_out, 8'hA5);

    // Short low glitch is rejected
    drive_level(1'b0, 3);
    settle(20);
    check("t2_glitch_ready", rx_ready, 1'b0);

    // Framing error followed by a held-low line, then a clean frame
    send_frame(8'h3C, 1'b0, -1);
    drive_level(1'b0, 20);
    @(negedge bclk); #1;
    check("t3_d_out", d_out, 8'h3C);
    check("t3_frame_err", frame_err, 1'b1);
    settle(10);
    pulse_rd();
    check("t3_ferr_cleared", frame_err, 1'b0);
    send_frame(8'h01, 1'b1, -1);
    settle(6);
    check("t3_next_frame", {d_out, rx_ready, frame_err, overrun_err}, {8'h01, 3'b100});
    pulse_rd();

    // Back-to-back frames without a read overrun the buffer
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    settle(6);
    check("t4_d_out", d_out, 8'h22);
    check("t4_overrun", overrun_err, 1'b1);
    pulse_rd();
    check("t4_cleared", {rx_ready, overrun_err}, 2'b00);

    // Read in the very cycle the second byte lands: no overrun
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 10 * OS - 2);
    settle(6);
    check("t5_state", {d_out, rx_ready, overrun_err}, {8'h22, 2'b10});
    pulse_rd();

    // Loopback-style bytes
    send_frame(8'h00, 1'b1, -1); settle(4);
    check("t6_00", {d_out, rx_ready, frame_err, overrun_err}, {8'h00, 3'b100});
    pulse_rd();
    send_frame(8'hFF, 1'b1, -1); settle(4);
    check("t6_FF", {d_out, rx_ready, frame_err, overrun_err}, {8'hFF, 3'b100});
    pulse_rd();
    send_frame(8'h55, 1'b1, -1); settle(4);
    check("t6_55", {d_out, rx_ready, frame_err, overrun_err}, {8'h55, 3'b100});

    // Reset in the middle of a frame (after data bit 3, during bit 4)
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h9C, 1'b0};
      for (int k = 0; k < 5 * OS + 3; k++) begin
        @(negedge bclk);
        rx_in = fr[k / OS];
      end
    end
    @(negedge bclk);
    reset = 1'b1; rx_in = 1'b1;
    #1;
    check("t6_reset_now", {d_out, rx_ready, frame_err, overrun_err}, 11'h000);
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    settle(10);
    check("t6_after_reset", rx_ready, 1'b0);
    send_frame(8'h5A, 1'b1, -1); settle(4);
    check("t6_clean_after_reset", {d_out, rx_ready, frame_err, overrun_err}, {8'h5A, 3'b100});
    pulse_rd();

    // Randomized traffic: frames, framing errors, breaks, glitches, random reads
    rnd_rd = 1'b1;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        drive_level(1'b0, $urandom_range(1, 3));
        drive_level(1'b1, $urandom_range(2, 12));
      end else begin
        b  = 8'($urandom_range(0, 255));
        st = ($urandom_range(0, 5) != 0);
        send_frame(b, st, -1);
        if (!st) drive_level(1'b0, $urandom_range(0, 15));
        drive_level(1'b1, $urandom_range(st ? 0 : 1, 12));
      end
    end
    rnd_rd = 1'b0;
    settle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
